system_out_port_n: RTL

- Parametrised successor of the single-port output-enable decode in the processor.
- Decodes processor register-file writes aimed at N memory-mapped output registers, starting at index BASE.
- Each hit is queued into a per-channel FIFO. Each FIFO drains to an external sink over a valid/ready handshake.
- Sits between the writeback stage and the board-level output pins/peripherals. Adds buffering, back-pressure (stall) and overflow reporting that the single-port decode lacks.

---
 rtl/system_out_port_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/system_out_port_n.sv
// system_out_port_n: decodes writeback register writes aimed at N memory-mapped
// output registers and queues each hit into a per-channel show-ahead FIFO that
// drains to an external sink over valid/ready. A full target FIFO either stalls
// the processor or drops the write and raises a sticky overflow flag.
module system_out_port_n #(
    parameter int N        = 2,
    parameter int BASE     = 4,
    parameter int REGW     = 5,
    parameter int DW       = 16,
    parameter int DEPTH    = 4,
    parameter int STALL_EN = 1
) (
    input  logic            system1000,
    input  logic            system1000_rst,
    input  logic [REGW-1:0] bufLast_i,
    input  logic [REGW-1:0] toReg_i,
    input  logic [1:0]      ldCode_i,
    input  logic [DW-1:0]   wrData_i,
    output logic [N-1:0]    oEn_o,
    output logic            stall_o,
    output logic [N*DW-1:0] out_data_o,
    output logic [N-1:0]    out_valid_o,
    input  logic [N-1:0]    out_ready_i,
    output logic [N-1:0]    overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam bit STALL = (STALL_EN != 0);

    logic [N-1:0]    hit_b;
    logic [N-1:0]    hit_t;
    logic [N-1:0]    sel_oh;
    logic [N-1:0]    full;
    logic [N-1:0]    pop;
    logic [N-1:0]    push_vec;
    logic [N-1:0]    drop_vec;
    logic            any_sel;
    logic            space;
    logic            push_ok;
    logic            blocked;

    logic [CW-1:0]   count  [N];
    logic [AW-1:0]   wr_ptr [N];
    logic [AW-1:0]   rd_ptr [N];
    logic [DW-1:0]   hold   [N];
    logic [DW-1:0]   mem    [N][DEPTH];

    // Address decode; indices that do not fit in REGW bits can never match.
    always_comb begin
        hit_b = '0;
        hit_t = '0;
        for (int c = 0; c < N; c++) begin
            if (BASE + c < (1 << REGW)) begin
                hit_b[c] = (bufLast_i == REGW'(BASE + c));
                hit_t[c] = (toReg_i == REGW'(BASE + c)) & ldCode_i[0];
            end
        end
    end

    assign oEn_o = hit_b | hit_t;

    // Buffered writeback wins; each hit vector is at most one-hot.
    assign sel_oh  = (|hit_b) ? hit_b : hit_t;
    assign any_sel = |sel_oh;

    // FIFO status per channel.
    always_comb begin
        full = '0;
        pop  = '0;
        for (int c = 0; c < N; c++) begin
            full[c] = (count[c] == CW'(DEPTH));
            pop[c]  = (count[c] != '0) & out_ready_i[c];
        end
    end

    // A full channel still accepts a push when it pops in the same cycle.
    assign space    = |(sel_oh & (~full | pop));
    assign push_ok  = any_sel & space & ~system1000_rst;
    assign blocked  = any_sel & ~space & ~system1000_rst;
    assign stall_o  = STALL & blocked;
    assign push_vec = sel_oh & {N{push_ok}};
    assign drop_vec = sel_oh & {N{blocked & ~STALL}};

    // Head-of-FIFO view; an empty channel keeps presenting the last popped word.
    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        for (int c = 0; c < N; c++) begin
            out_valid_o[c] = (count[c] != '0);
            out_data_o[c*DW +: DW] = (count[c] != '0) ? mem[c][rd_ptr[c]] : hold[c];
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge system1000) begin
        for (int c = 0; c < N; c++) begin
            if (push_vec[c]) begin
                mem[c][wr_ptr[c]] <= wrData_i;
            end
        end
    end

    // Pointer, count, hold-register and overflow bookkeeping.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int c = 0; c < N; c++) begin
                count[c]  <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                hold[c]   <= '0;
            end
            overflow_o <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (push_vec[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    hold[c]   <= mem[c][rd_ptr[c]];
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                case ({push_vec[c], pop[c]})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
                if (drop_vec[c]) begin
                    overflow_o[c] <= 1'b1;
                end
            end
        end
    end

endmodule
